// File: rtl/pipe_pkg.sv
// Shared definitions for the ID/EX operand selection datapath.
package pipe_pkg;

    localparam int WORD_W = 32;

    typedef enum int {
        SEL_RF    = 0,
        SEL_EXMEM = 1,
        SEL_MEMWB = 2,
        SEL_IMM   = 3
    } sel_e;

    function automatic int sel_width(input int n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mux_n.sv
// Combinational NUM_IN:1 word mux; out-of-range selects fall back to input 0.
module mux_n
    import pipe_pkg::*;
#(
    parameter  int WIDTH  = WORD_W,
    parameter  int NUM_IN = 4,
    localparam int SEL_W  = sel_width(NUM_IN)
) (
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        sel,
    output logic [WIDTH-1:0]        out_data,
    output logic                    oor
);

    always_comb begin
        out_data = in_data[WIDTH-1:0];
        oor      = 1'b1;
        for (int k = 0; k < NUM_IN; k++) begin
            if (sel == SEL_W'(k)) begin
                out_data = in_data[k*WIDTH +: WIDTH];
                oor      = 1'b0;
            end
        end
    end

endmodule

// File: rtl/pipe_sel_reg.sv
// Registered N-way operand selector at the ID/EX boundary.
// Optional forwarding-use counter enabled by PIPE_SEL_REG_FWD_CNT_EN.
module pipe_sel_reg
    import pipe_pkg::*;
#(
    parameter  int WIDTH  = WORD_W,
    parameter  int NUM_IN = 4,
    parameter  int CNT_W  = 16,
    localparam int SEL_W  = sel_width(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    in_valid,
    input  logic                    stall,
    input  logic                    flush,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    output logic [SEL_W-1:0]        out_sel,
    output logic                    sel_err
`ifdef PIPE_SEL_REG_FWD_CNT_EN
    ,
    output logic [CNT_W-1:0]        fwd_cnt
`endif
);

    if (WIDTH < 1 || NUM_IN < 2 || CNT_W < 1) begin : g_bad_cfg
        $error("pipe_sel_reg: invalid parameter set");
    end

    logic [WIDTH-1:0] mux_data;
    logic             mux_oor;
    logic             load;

    mux_n #(
        .WIDTH  (WIDTH),
        .NUM_IN (NUM_IN)
    ) u_mux (
        .in_data  (in_data),
        .sel      (sel),
        .out_data (mux_data),
        .oor      (mux_oor)
    );

    assign load = !flush && !stall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            out_sel   <= '0;
            sel_err   <= 1'b0;
        end else if (flush) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            out_sel   <= '0;
            sel_err   <= 1'b0;
        end else if (!stall) begin
            out_data  <= mux_data;
            out_valid <= in_valid;
            out_sel   <= mux_oor ? '0 : sel;
            sel_err   <= mux_oor;
        end
    end

`ifdef PIPE_SEL_REG_FWD_CNT_EN
    logic fwd_hit;

    // Only valid, in-range non-regfile selects count as forwarding uses.
    assign fwd_hit = load && in_valid && !mux_oor &&
                     (sel != SEL_W'(SEL_RF));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fwd_cnt <= '0;
        end else if (fwd_hit && (fwd_cnt != '1)) begin
            fwd_cnt <= fwd_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_sel_reg.sv
// Directed scoreboard bench for pipe_sel_reg (NUM_IN=4 and NUM_IN=3).
module tb_pipe_sel_reg;

    typedef struct packed {
        logic [31:0] d;
        logic        v;
        logic [1:0]  s;
        logic        e;
        logic [3:0]  c;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [127:0] din = '0;
    logic [1:0]   sel = '0;
    logic         vld = 1'b0;
    logic         stall = 1'b0;
    logic         flush = 1'b0;

    logic [31:0]  d4, d3;
    logic         v4, v3;
    logic [1:0]   s4, s3;
    logic         e4, e3;
    logic [3:0]   c4, c3;

    exp_t m4, m3, x;
    exp_t q4[$];
    exp_t q3[$];
    int   total = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    pipe_sel_reg #(.WIDTH(32), .NUM_IN(4), .CNT_W(4)) u4 (
        .clk       (clk),
        .reset     (reset),
        .in_data   (din),
        .sel       (sel),
        .in_valid  (vld),
        .stall     (stall),
        .flush     (flush),
        .out_data  (d4),
        .out_valid (v4),
        .out_sel   (s4),
        .sel_err   (e4)
`ifdef PIPE_SEL_REG_FWD_CNT_EN
        ,
        .fwd_cnt   (c4)
`endif
    );

    pipe_sel_reg #(.WIDTH(32), .NUM_IN(3), .CNT_W(4)) u3 (
        .clk       (clk),
        .reset     (reset),
        .in_data   (din[95:0]),
        .sel       (sel),
        .in_valid  (vld),
        .stall     (stall),
        .flush     (flush),
        .out_data  (d3),
        .out_valid (v3),
        .out_sel   (s3),
        .sel_err   (e3)
`ifdef PIPE_SEL_REG_FWD_CNT_EN
        ,
        .fwd_cnt   (c3)
`endif
    );

`ifndef PIPE_SEL_REG_FWD_CNT_EN
    assign c4 = '0;
    assign c3 = '0;
`endif

    function automatic exp_t nxt(input exp_t cur, input int n);
        exp_t r;
        r = cur;
        if (flush) begin
            r.d = '0;
            r.v = 1'b0;
            r.s = '0;
            r.e = 1'b0;
        end else if (!stall) begin
            if (int'(sel) < n) begin
                r.d = din[sel*32 +: 32];
                r.s = sel;
                r.e = 1'b0;
                if (vld && sel != 2'd0 && r.c != 4'hf)
                    r.c = r.c + 4'd1;
            end else begin
                r.d = din[31:0];
                r.s = '0;
                r.e = 1'b1;
            end
            r.v = vld;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic cmp(input string who, input exp_t e,
                       input logic [31:0] d, input logic v,
                       input logic [1:0] s, input logic er,
                       input logic [3:0] c);
        chk({who, ".data"}, d, e.d);
        chk({who, ".valid"}, {31'd0, v}, {31'd0, e.v});
        chk({who, ".sel"}, {30'd0, s}, {30'd0, e.s});
        chk({who, ".err"}, {31'd0, er}, {31'd0, e.e});
`ifdef PIPE_SEL_REG_FWD_CNT_EN
        chk({who, ".cnt"}, {28'd0, c}, {28'd0, e.c});
`endif
    endtask

    task automatic step();
        q4.push_back(nxt(m4, 4));
        m4 = q4[$];
        q3.push_back(nxt(m3, 3));
        m3 = q3[$];
        @(posedge clk);
        #1;
        x = q4.pop_front();
        cmp("n4", x, d4, v4, s4, e4, c4);
        x = q3.pop_front();
        cmp("n3", x, d3, v3, s3, e3, c3);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".n4.data"}, d4, 32'd0);
        chk({tag, ".n4.ctl"}, {28'd0, v4, s4, e4}, 32'd0);
        chk({tag, ".n4.cnt"}, {28'd0, c4}, 32'd0);
        chk({tag, ".n3.data"}, d3, 32'd0);
        chk({tag, ".n3.ctl"}, {28'd0, v3, s3, e3}, 32'd0);
    endtask

    initial begin
        m4 = '0;
        m3 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset_state");
        reset = 1'b0;

        // load a marker word, then reset asynchronously mid-cycle
        din = {32'h0, 32'h0, 32'h0, 32'hdeadbeef};
        sel = 2'd0;
        vld = 1'b1;
        step();
        #3 reset = 1'b1;
        #1 chk_zero("async_reset");
        #2 reset = 1'b0;
        m4 = '0;
        m3 = '0;

        // select sweep; sel=3 is out of range for the 3-input copy
        din = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        for (int i = 0; i < 4; i++) begin
            sel = 2'(i);
            step();
        end
        stall = 1'b1;
        step();
        stall = 1'b0;
        sel = 2'd1;
        step();

        // stall holds across changing inputs, flush wins over stall
        sel = 2'd2;
        step();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            din = {4{32'($urandom)}};
            sel = 2'($urandom_range(0, 3));
            step();
        end
        flush = 1'b1;
        step();
        stall = 1'b0;
        flush = 1'b0;

        // bubble load still captures data
        din = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        vld = 1'b0;
        sel = 2'd1;
        step();
        vld = 1'b1;

        // counter: stalls and sel=0 loads do not count, then saturate
        sel = 2'd0;
        step();
        sel = 2'd1;
        stall = 1'b1;
        step();
        stall = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
        end
        flush = 1'b1;
        step();
        flush = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
